axi_fabric_regs_v2: RTL and testbench

AXI4-Lite control/status slave for the ternary fabric, generalised to a parametrised lane count. It adds full AXI-Lite flow control, byte strobes, decode-error responses, a busy/done run-control state machine with a start pulse and config lock, and an optional completion interrupt. It sits between the host AXI-Lite port and the fabric core. It drives the run configuration and the weight/input SRAM write ports, and reads back per-lane results and the cycle counter.

---
 rtl/axi_fabric_regs_v2_if.sv | 32 +++
 rtl/axi_fabric_regs_v2.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_axi_fabric_regs_v2.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_fabric_regs_v2_if.sv
// AXI4-Lite bus bundle between the host port and the fabric control/status slave.
interface axi_fabric_regs_v2_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_fabric_regs_v2.sv
// AXI4-Lite run-control, config and SRAM-load slave for the ternary fabric.
// Optional completion interrupt enabled by defining FABRIC_IRQ_EN.
module axi_fabric_regs_v2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LANES  = 15,
  parameter int SRAM_AW    = 10
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  axi_fabric_regs_v2_if.slave     s_axi,
  output logic [31:0]             fabric_base_addr,
  output logic [15:0]             fabric_depth,
  output logic [7:0]              fabric_stride,
  output logic [31:0]             fabric_exec_hints,
  output logic [15:0]             fabric_lane_count,
  output logic [NUM_LANES-1:0]    fabric_lane_mask,
  output logic                    fabric_start,
  input  logic                    fabric_done,
  input  logic [NUM_LANES*32-1:0] vector_results,
  input  logic [31:0]             cycle_count,
  output logic [SRAM_AW-1:0]      sram_waddr,
  output logic [23:0]             sram_wdata,
  output logic                    sram_we_weight,
  output logic                    sram_we_input,
  output logic                    irq
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic   busy;
  logic   done;
  logic   done_set;

  logic        aw_full, w_full;
  logic [15:0] aw_off;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [15:0] wr_off, rd_off;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic wr_err, start_req, clr_req, we_w_req, we_i_req;
  logic sel_base, sel_depth, sel_stride, sel_hints, sel_lcnt, sel_mask, sel_irqen;

  logic [31:0]          m_base, m_hints;
  logic [15:0]          m_depth, m_lcnt, lcnt_clamped;
  logic [7:0]           m_stride;
  logic [NUM_LANES-1:0] m_mask;

  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_lane_hit, rd_lane_hit;

`ifdef FABRIC_IRQ_EN
  logic irq_en;
  logic irq_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:0], s_axi.araddr, wr_off, rd_off, wr_data};

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid && s_axi.wready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign commit = (aw_full || aw_hs) && (w_full || w_hs);

  // The committing write may use a channel latched earlier or one arriving this cycle
  assign wr_off  = aw_full ? aw_off : s_axi.awaddr[15:0];
  assign wr_data = w_full ? w_data : s_axi.wdata;
  assign wr_strb = w_full ? w_strb : s_axi.wstrb;
  assign rd_off  = s_axi.araddr[15:0];

  assign s_axi.awready = !aw_full && !bvalid_q;
  assign s_axi.wready  = !w_full && !bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign wr_lane_hit = (wr_off[15:2] >= 14'h040) && (wr_off[15:2] < 14'(64 + NUM_LANES));
  assign rd_lane_hit = (rd_off[15:2] >= 14'h040) && (rd_off[15:2] < 14'(64 + NUM_LANES));

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (commit && start_req) state_next = BUSY;
      BUSY: if (fabric_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == BUSY);
    done_set = (state == BUSY) && fabric_done;
  end

  // Write decode: errors and side-effect requests are mutually exclusive
  always_comb begin
    wr_err     = 1'b0;
    start_req  = 1'b0;
    clr_req    = 1'b0;
    we_w_req   = 1'b0;
    we_i_req   = 1'b0;
    sel_base   = 1'b0;
    sel_depth  = 1'b0;
    sel_stride = 1'b0;
    sel_hints  = 1'b0;
    sel_lcnt   = 1'b0;
    sel_mask   = 1'b0;
    sel_irqen  = 1'b0;
    if (wr_off[15:12] == 4'h1 || wr_off[15:12] == 4'h2) begin
      if (busy || wr_strb[2:0] != 3'b111) wr_err = 1'b1;
      else if (wr_off[12])                  we_w_req = 1'b1;
      else                                  we_i_req = 1'b1;
    end else if (wr_lane_hit) begin
      wr_err = 1'b0;
    end else begin
      case (wr_off[15:2])
        14'h000: begin
          clr_req = wr_strb[0] && wr_data[1];
          if (wr_strb[0] && wr_data[0]) begin
            if (busy) wr_err = 1'b1;
            else      start_req = 1'b1;
          end
        end
        14'h001, 14'h008: wr_err = 1'b0;
        14'h002: if (busy) wr_err = 1'b1; else sel_base   = 1'b1;
        14'h003: if (busy) wr_err = 1'b1; else sel_depth  = 1'b1;
        14'h004: if (busy) wr_err = 1'b1; else sel_stride = 1'b1;
        14'h005: if (busy) wr_err = 1'b1; else sel_hints  = 1'b1;
        14'h006: if (busy) wr_err = 1'b1; else sel_lcnt   = 1'b1;
        14'h007: if (busy) wr_err = 1'b1; else sel_mask   = 1'b1;
`ifdef FABRIC_IRQ_EN
        14'h009: sel_irqen = wr_strb[0];
`endif
        default: wr_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    m_base   = fabric_base_addr;
    m_hints  = fabric_exec_hints;
    m_depth  = fabric_depth;
    m_lcnt   = fabric_lane_count;
    m_stride = fabric_stride;
    m_mask   = fabric_lane_mask;
    for (int b = 0; b < 32; b++) begin
      if (wr_strb[b/8]) begin
        m_base[b]  = wr_data[b];
        m_hints[b] = wr_data[b];
      end
    end
    for (int b = 0; b < 16; b++) begin
      if (wr_strb[b/8]) begin
        m_depth[b] = wr_data[b];
        m_lcnt[b]  = wr_data[b];
      end
    end
    for (int b = 0; b < 8; b++) begin
      if (wr_strb[0]) m_stride[b] = wr_data[b];
    end
    for (int b = 0; b < NUM_LANES; b++) begin
      if (wr_strb[b/8]) m_mask[b] = wr_data[b];
    end
    if (m_lcnt == 16'd0)                   lcnt_clamped = 16'd1;
    else if (m_lcnt > 16'(NUM_LANES))      lcnt_clamped = 16'(NUM_LANES);
    else                                   lcnt_clamped = m_lcnt;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_off   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (commit) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_err ? 2'b10 : 2'b00;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_off  <= s_axi.awaddr[15:0];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      fabric_base_addr  <= '0;
      fabric_depth      <= '0;
      fabric_stride     <= '0;
      fabric_exec_hints <= '0;
      fabric_lane_count <= 16'(NUM_LANES);
      fabric_lane_mask  <= '1;
      fabric_start      <= 1'b0;
      sram_waddr        <= '0;
      sram_wdata        <= '0;
      sram_we_weight    <= 1'b0;
      sram_we_input     <= 1'b0;
      done              <= 1'b0;
    end else begin
      fabric_start   <= commit && start_req;
      sram_we_weight <= commit && we_w_req;
      sram_we_input  <= commit && we_i_req;
      if (commit && (we_w_req || we_i_req)) begin
        sram_waddr <= wr_off[SRAM_AW+1:2];
        sram_wdata <= wr_data[23:0];
      end
      if (commit && sel_base)   fabric_base_addr  <= m_base;
      if (commit && sel_depth)  fabric_depth      <= m_depth;
      if (commit && sel_stride) fabric_stride     <= m_stride;
      if (commit && sel_hints)  fabric_exec_hints <= m_hints;
      if (commit && sel_lcnt)   fabric_lane_count <= lcnt_clamped;
      if (commit && sel_mask)   fabric_lane_mask  <= m_mask;
      // Completion outranks a simultaneous clear so a finished run is never lost
      if (done_set)                              done <= 1'b1;
      else if (commit && (start_req || clr_req)) done <= 1'b0;
    end
  end

`ifdef FABRIC_IRQ_EN
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (commit && sel_irqen) irq_en <= wr_data[0];
      irq_q <= done && irq_en;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_off[15:12] == 4'h1 || rd_off[15:12] == 4'h2) begin
      rd_data = '0;
    end else if (rd_lane_hit) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (rd_off[15:2] == 14'(64 + i)) rd_data = vector_results[i*32 +: 32];
      end
    end else begin
      case (rd_off[15:2])
        14'h000: rd_data = '0;
        14'h001: rd_data = {29'd0, irq, done, busy};
        14'h002: rd_data = fabric_base_addr;
        14'h003: rd_data = {16'd0, fabric_depth};
        14'h004: rd_data = {24'd0, fabric_stride};
        14'h005: rd_data = fabric_exec_hints;
        14'h006: rd_data = {16'd0, fabric_lane_count};
        14'h007: rd_data = 32'(fabric_lane_mask);
        14'h008: rd_data = cycle_count;
`ifdef FABRIC_IRQ_EN
        14'h009: rd_data = {31'd0, irq_en};
`endif
        default: rd_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_err ? 2'b10 : 2'b00;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_fabric_regs_v2.sv
// Directed bench for axi_fabric_regs_v2: register vector table plus hand-written run/SRAM/reset sequences.
module tb_axi_fabric_regs_v2;

  localparam int NL = 15;
  localparam int NV = 29;

  logic                 clk;
  logic                 rst_n;
  logic [31:0]          fabric_base_addr, fabric_exec_hints;
  logic [15:0]          fabric_depth, fabric_lane_count;
  logic [7:0]           fabric_stride;
  logic [NL-1:0]        fabric_lane_mask;
  logic                 fabric_start, fabric_done;
  logic [NL*32-1:0]     vector_results;
  logic [31:0]          cycle_count;
  logic [9:0]           sram_waddr;
  logic [23:0]          sram_wdata;
  logic                 sram_we_weight, sram_we_input, irq;

  int vectors_applied = 0;
  int miscompares = 0;
  int start_cnt = 0, we_w_cnt = 0, we_i_cnt = 0;
  logic [9:0]  last_waddr;
  logic [23:0] last_wdata;

  axi_fabric_regs_v2_if #(.ADDR_WIDTH(32)) bus ();

  axi_fabric_regs_v2 #(.ADDR_WIDTH(32), .NUM_LANES(NL), .SRAM_AW(10)) dut (
    .s_axi_aclk        (clk),
    .s_axi_aresetn     (rst_n),
    .s_axi             (bus.slave),
    .fabric_base_addr  (fabric_base_addr),
    .fabric_depth      (fabric_depth),
    .fabric_stride     (fabric_stride),
    .fabric_exec_hints (fabric_exec_hints),
    .fabric_lane_count (fabric_lane_count),
    .fabric_lane_mask  (fabric_lane_mask),
    .fabric_start      (fabric_start),
    .fabric_done       (fabric_done),
    .vector_results    (vector_results),
    .cycle_count       (cycle_count),
    .sram_waddr        (sram_waddr),
    .sram_wdata        (sram_wdata),
    .sram_we_weight    (sram_we_weight),
    .sram_we_input     (sram_we_input),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fabric_start) start_cnt++;
    if (sram_we_weight) begin
      we_w_cnt++;
      last_waddr = sram_waddr;
      last_wdata = sram_wdata;
    end
    if (sram_we_input) begin
      we_i_cnt++;
      last_waddr = sram_waddr;
      last_wdata = sram_wdata;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] r, logic [31:0] rd, string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd; v.name = n;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_take, w_take;
    int n;
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_take = bus.awvalid && bus.awready;
      w_take  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_take) bus.awvalid = 1'b0;
      if (w_take)  bus.wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bus.bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.bvalid) begin
      check_output("bvalid_timeout", 32'd0, 32'd1);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      resp = 2'b11;
    end else begin
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit take;
    int n;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 50) begin
      take = bus.arready;
      @(negedge clk);
      if (take) bus.arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rvalid) begin
      check_output("rvalid_timeout", 32'd0, 32'd1);
      bus.arvalid = 1'b0;
      data = 32'hFFFF_FFFF; resp = 2'b11;
    end else begin
      data = bus.rdata; resp = bus.rresp;
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [1:0]  r;
    logic [31:0] d;
    if (v.is_wr) begin
      axi_write(v.addr, v.data, v.strb, r);
      check_output({v.name, "_bresp"}, 32'(r), 32'(v.resp));
    end else begin
      axi_read(v.addr, d, r);
      check_output({v.name, "_rresp"}, 32'(r), 32'(v.resp));
      check_output({v.name, "_rdata"}, d, v.rdata);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    fabric_done = 1'b1;
    @(negedge clk);
    fabric_done = 1'b0;
  endtask

  initial begin : main
    logic [1:0]  r;
    logic [31:0] d;
    int          c0, c1;
    int          n;

    vecs[0]  = mk(0, 32'h018, 0, 0, 2'b00, 32'h0000_000F, "lcnt_rst");
    vecs[1]  = mk(0, 32'h01C, 0, 0, 2'b00, 32'h0000_7FFF, "mask_rst");
    vecs[2]  = mk(0, 32'h0FC, 0, 0, 2'b10, 32'h0, "rd_hole");
    vecs[3]  = mk(0, 32'h008, 0, 0, 2'b00, 32'h0, "base_rst");
    vecs[4]  = mk(1, 32'h008, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, "base_wr");
    vecs[5]  = mk(0, 32'h008, 0, 0, 2'b00, 32'hDEAD_BEEF, "base_rd");
    vecs[6]  = mk(1, 32'h008, 32'h1122_3344, 4'b0110, 2'b00, 0, "base_strb_wr");
    vecs[7]  = mk(0, 32'h008, 0, 0, 2'b00, 32'hDE22_33EF, "base_strb_rd");
    vecs[8]  = mk(1, 32'h010, 32'hFFFF_FFA5, 4'hF, 2'b00, 0, "stride_wr");
    vecs[9]  = mk(0, 32'h010, 0, 0, 2'b00, 32'h0000_00A5, "stride_rd");
    vecs[10] = mk(1, 32'h018, 32'd0, 4'hF, 2'b00, 0, "lcnt0_wr");
    vecs[11] = mk(0, 32'h018, 0, 0, 2'b00, 32'd1, "lcnt0_rd");
    vecs[12] = mk(1, 32'h018, 32'd99, 4'hF, 2'b00, 0, "lcnt99_wr");
    vecs[13] = mk(0, 32'h018, 0, 0, 2'b00, 32'd15, "lcnt99_rd");
    vecs[14] = mk(1, 32'h018, 32'd7, 4'hF, 2'b00, 0, "lcnt7_wr");
    vecs[15] = mk(0, 32'h018, 0, 0, 2'b00, 32'd7, "lcnt7_rd");
    vecs[16] = mk(1, 32'h01C, 32'hFFFF_0003, 4'hF, 2'b00, 0, "mask_wr");
    vecs[17] = mk(0, 32'h01C, 0, 0, 2'b00, 32'h0000_0003, "mask_rd");
    vecs[18] = mk(1, 32'h014, 32'hCAFE_F00D, 4'hF, 2'b00, 0, "hints_wr");
    vecs[19] = mk(0, 32'h014, 0, 0, 2'b00, 32'hCAFE_F00D, "hints_rd");
    vecs[20] = mk(0, 32'h138, 0, 0, 2'b00, 32'hC0DE_000E, "lane_last");
    vecs[21] = mk(0, 32'h100, 0, 0, 2'b00, 32'hC0DE_0000, "lane_first");
    vecs[22] = mk(0, 32'h13C, 0, 0, 2'b10, 32'h0, "lane_oob");
    vecs[23] = mk(0, 32'h020, 0, 0, 2'b00, 32'h00BA_DA55, "cycles");
    vecs[24] = mk(1, 32'h0FC, 32'h1234_5678, 4'hF, 2'b10, 0, "wr_hole");
    vecs[25] = mk(0, 32'h004, 0, 0, 2'b00, 32'h0, "status_idle");
    vecs[26] = mk(1, 32'h01C, 32'h0000_0000, 4'h0, 2'b00, 0, "mask_nostrb_wr");
    vecs[27] = mk(0, 32'h01C, 0, 0, 2'b00, 32'h0000_0003, "mask_nostrb_rd");
    vecs[28] = mk(1, 32'h000, 32'h0, 4'hF, 2'b00, 0, "ctrl_noop");

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    fabric_done = 1'b0;
    cycle_count = 32'h00BA_DA55;
    for (int i = 0; i < NL; i++) vector_results[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_base", fabric_base_addr, 32'h0);
    check_output("rst_depth", 32'(fabric_depth), 32'h0);
    check_output("rst_stride", 32'(fabric_stride), 32'h0);
    check_output("rst_hints", fabric_exec_hints, 32'h0);
    check_output("rst_lcnt", 32'(fabric_lane_count), 32'd15);
    check_output("rst_mask", 32'(fabric_lane_mask), 32'h7FFF);
    check_output("rst_ctl", {26'd0, fabric_start, sram_we_weight, sram_we_input, irq, bus.bvalid, bus.rvalid}, 32'h0);
    check_output("rst_sram", {sram_waddr, sram_wdata}, 34'h0);
    check_output("rst_ready", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);
    check_output("rst_resp", {28'd0, bus.bresp, bus.rresp}, 32'h0);

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) apply_stimulus(vecs[i]);
    check_output("port_base", fabric_base_addr, 32'hDE22_33EF);
    check_output("port_stride", 32'(fabric_stride), 32'hA5);
    check_output("port_hints", fabric_exec_hints, 32'hCAFE_F00D);
    check_output("port_lcnt", 32'(fabric_lane_count), 32'd7);
    check_output("port_mask", 32'(fabric_lane_mask), 32'h3);

    $display("[TB] split AW/W write");
    @(negedge clk);
    bus.awaddr = 32'h00C; bus.awvalid = 1'b1;
    check_output("split_awready", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_output("split_no_early_b0", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    check_output("split_no_early_b1", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    bus.wdata = 32'h1234; bus.wstrb = 4'b0001; bus.wvalid = 1'b1;
    check_output("split_wready", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0;
    check_output("split_b_latency", 32'(bus.bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_output("split_b_hold", {30'd0, bus.bvalid, bus.bresp == 2'b00}, 32'h3);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check_output("split_b_drop", 32'(bus.bvalid), 32'd0);
    axi_read(32'h00C, d, r);
    check_output("split_depth", d, 32'h0000_0034);

    $display("[TB] run control");
    c0 = start_cnt;
    axi_write(32'h000, 32'h1, 4'hF, r);
    check_output("start_bresp", 32'(r), 32'd0);
    check_output("start_pulse_len", 32'(start_cnt - c0), 32'd1);
    axi_read(32'h004, d, r);
    check_output("status_busy", d, 32'h1);
    axi_write(32'h008, 32'h55, 4'hF, r);
    check_output("busy_cfg_bresp", 32'(r), 32'd2);
    axi_read(32'h008, d, r);
    check_output("busy_cfg_kept", d, 32'hDE22_33EF);
    c0 = we_w_cnt;
    axi_write(32'h1000, 32'h00AA_AAAA, 4'hF, r);
    check_output("busy_sram_bresp", 32'(r), 32'd2);
    check_output("busy_sram_no_we", 32'(we_w_cnt - c0), 32'd0);
    c0 = start_cnt;
    axi_write(32'h000, 32'h1, 4'hF, r);
    check_output("busy_start_bresp", 32'(r), 32'd2);
    check_output("busy_start_no_pulse", 32'(start_cnt - c0), 32'd0);

    // STATUS read and fabric_done in the same cycle
    @(negedge clk);
    bus.araddr = 32'h004; bus.arvalid = 1'b1; fabric_done = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0; fabric_done = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    check_output("status_pre_done", bus.rdata, 32'h1);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    axi_read(32'h004, d, r);
    check_output("status_done", d, 32'h2);
    check_output("irq_idle", 32'(irq), 32'd0);
    axi_write(32'h000, 32'h2, 4'hF, r);
    axi_read(32'h004, d, r);
    check_output("status_cleared", d, 32'h0);
    pulse_done();
    axi_read(32'h004, d, r);
    check_output("done_ignored_idle", d, 32'h0);

`ifdef FABRIC_IRQ_EN
    $display("[TB] interrupt");
    axi_write(32'h024, 32'h1, 4'hF, r);
    check_output("irqen_bresp", 32'(r), 32'd0);
    axi_read(32'h024, d, r);
    check_output("irqen_rd", d, 32'h1);
    axi_write(32'h000, 32'h1, 4'hF, r);
    pulse_done();
    check_output("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    check_output("irq_rise", 32'(irq), 32'd1);
    axi_read(32'h004, d, r);
    check_output("status_irq", d, 32'h6);
    axi_write(32'h000, 32'h2, 4'hF, r);
    check_output("irq_clr_done", 32'(irq), 32'd0);
    axi_read(32'h004, d, r);
    check_output("status_irq_clr", d, 32'h0);
    axi_write(32'h000, 32'h1, 4'hF, r);
    pulse_done();
    @(negedge clk);
    check_output("irq_rise2", 32'(irq), 32'd1);
    axi_write(32'h024, 32'h0, 4'hF, r);
    check_output("irq_en_off", 32'(irq), 32'd0);
    axi_write(32'h000, 32'h2, 4'hF, r);
`else
    $display("[TB] interrupt disabled build");
    axi_write(32'h024, 32'h1, 4'hF, r);
    check_output("irqen_wr_slverr", 32'(r), 32'd2);
    axi_read(32'h024, d, r);
    check_output("irqen_rd_slverr", 32'(r), 32'd2);
    check_output("irqen_rd_zero", d, 32'h0);
    axi_write(32'h000, 32'h1, 4'hF, r);
    pulse_done();
    @(negedge clk);
    check_output("irq_tied", 32'(irq), 32'd0);
    axi_read(32'h004, d, r);
    check_output("status_no_irq", d, 32'h2);
    axi_write(32'h000, 32'h2, 4'hF, r);
`endif

    $display("[TB] SRAM writes");
    c0 = we_w_cnt; c1 = we_i_cnt;
    axi_write(32'h1004, 32'hFFAB_CDEF, 4'hF, r);
    check_output("wsram_bresp", 32'(r), 32'd0);
    check_output("wsram_we_len", 32'(we_w_cnt - c0), 32'd1);
    check_output("wsram_waddr", 32'(last_waddr), 32'd1);
    check_output("wsram_wdata", 32'(last_wdata), 32'h00AB_CDEF);
    check_output("wsram_no_input", 32'(we_i_cnt - c1), 32'd0);
    axi_write(32'h2008, 32'h0012_3456, 4'h3, r);
    check_output("isram_strb_bresp", 32'(r), 32'd2);
    check_output("isram_strb_no_we", 32'(we_i_cnt - c1), 32'd0);
    axi_write(32'h2008, 32'h0012_3456, 4'h7, r);
    check_output("isram_bresp", 32'(r), 32'd0);
    check_output("isram_we_len", 32'(we_i_cnt - c1), 32'd1);
    check_output("isram_waddr", 32'(last_waddr), 32'd2);
    check_output("isram_wdata", 32'(last_wdata), 32'h0012_3456);
    check_output("isram_no_weight", 32'(we_w_cnt - c0), 32'd1);

    $display("[TB] reset mid-transaction");
    @(negedge clk);
    bus.awaddr = 32'h008; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_output("mid_aw_latched", 32'(bus.awready), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("mid_ready", {29'd0, bus.awready, bus.wready, bus.bvalid}, 32'h6);
    check_output("mid_base", fabric_base_addr, 32'h0);
    check_output("mid_lcnt", 32'(fabric_lane_count), 32'd15);
    bus.wdata = 32'h0000_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("mid_no_stale_b", 32'(bus.bvalid), 32'd0);
    bus.awaddr = 32'h010; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_output("mid_late_aw_b", {30'd0, bus.bvalid, bus.bresp == 2'b00}, 32'h3);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check_output("mid_stride", 32'(fabric_stride), 32'h01);
    check_output("mid_base_kept", fabric_base_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
